// File: rtl/lvdc_serial_loader_if.sv
// Word-load handshake between a producer and the LVDC serial loader.
interface lvdc_serial_loader_if #(
  parameter int WORD_W = 26
) ();
  logic [WORD_W-1:0] wdata;
  logic              wvalid;
  logic              wready;

  modport master (output wdata, output wvalid, input wready);
  modport slave  (input wdata, input wvalid, output wready);
endinterface

// File: rtl/lvdc_serial_loader.sv
// Buffers parallel words in a small FIFO and shifts them MSB-first onto the
// LVDC serial input with DATAV framing, optional odd parity and an INTCV pulse.
module lvdc_serial_loader #(
  parameter int WORD_W     = 26,
  parameter int PARITY_EN  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_DIV    = 4,
  parameter int GAP_CYC    = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  lvdc_serial_loader_if.slave               wr,
  input  logic                              hold,
  output logic                              din,
  output logic                              datav,
  output logic                              intcv,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level
);
  localparam int NB  = WORD_W + PARITY_EN;
  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BCW = $clog2(NB);
  localparam int DCW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int GCW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [LW-1:0]  FULL_CNT = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]  LW_ONE   = LW'(1);
  localparam logic [AW-1:0]  AW_ONE   = AW'(1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(NB - 1);
  localparam logic [BCW-1:0] BCW_ONE  = BCW'(1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(BIT_DIV - 1);
  localparam logic [DCW-1:0] DCW_ONE  = DCW'(1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYC - 1);
  localparam logic [GCW-1:0] GCW_ONE  = GCW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Data plus parity must carry an odd number of ones.
  function automatic logic odd_parity(input logic [WORD_W-1:0] d);
    return ~(^d);
  endfunction

  logic [WORD_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wptr_r, rptr_r;
  logic [LW-1:0]     count_r, count_s;
  logic              wready_r;

  state_t            state_r, state_s;
  logic [NB-1:0]     sreg_r, sreg_s, load_s;
  logic [BCW-1:0]    bit_cnt_r, bit_cnt_s;
  logic [DCW-1:0]    div_cnt_r, div_cnt_s;
  logic [GCW-1:0]    gap_cnt_r, gap_cnt_s;
  logic              din_r, din_s, datav_r, datav_s, intcv_r, intcv_s, busy_r;
  logic              push_s, pop_s;
  logic [WORD_W-1:0] head_s;

  assign head_s = mem_r[rptr_r];
  assign push_s = wr.wvalid & wready_r;

  if (PARITY_EN != 0) begin : g_par
    assign load_s = {head_s, odd_parity(head_s)};
  end else begin : g_nopar
    assign load_s = head_s;
  end

  // FIFO occupancy after this cycle's push and pop.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + LW_ONE;
      2'b01:   count_s = count_r - LW_ONE;
      default: count_s = count_r;
    endcase
  end

  // Serializer next-state and next-output logic.
  always_comb begin
    state_s   = state_r;
    sreg_s    = sreg_r;
    bit_cnt_s = bit_cnt_r;
    div_cnt_s = div_cnt_r;
    gap_cnt_s = gap_cnt_r;
    din_s     = din_r;
    datav_s   = datav_r;
    intcv_s   = 1'b0;
    pop_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((count_r != '0) && !hold) begin
          pop_s     = 1'b1;
          sreg_s    = load_s;
          bit_cnt_s = '0;
          div_cnt_s = '0;
          gap_cnt_s = '0;
          din_s     = load_s[NB-1];
          datav_s   = 1'b1;
          state_s   = ST_SHIFT;
        end else begin
          din_s   = 1'b0;
          datav_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_s = '0;
          if (bit_cnt_r == BIT_LAST) begin
            state_s   = ST_GAP;
            din_s     = 1'b0;
            datav_s   = 1'b0;
            intcv_s   = 1'b1;
            gap_cnt_s = '0;
          end else begin
            bit_cnt_s = bit_cnt_r + BCW_ONE;
            sreg_s    = {sreg_r[NB-2:0], 1'b0};
            din_s     = sreg_r[NB-2];
          end
        end else begin
          div_cnt_s = div_cnt_r + DCW_ONE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s   = ST_IDLE;
          gap_cnt_s = '0;
        end else begin
          gap_cnt_s = gap_cnt_r + GCW_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        din_s   = 1'b0;
        datav_s = 1'b0;
      end
    endcase
  end

  // FIFO storage; stale entries are harmless because the count gates reads.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r] <= wr.wdata;
    end
  end

  // Pointers, count, serializer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r    <= '0;
      rptr_r    <= '0;
      count_r   <= '0;
      wready_r  <= 1'b1;
      state_r   <= ST_IDLE;
      sreg_r    <= '0;
      bit_cnt_r <= '0;
      div_cnt_r <= '0;
      gap_cnt_r <= '0;
      din_r     <= 1'b0;
      datav_r   <= 1'b0;
      intcv_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      wptr_r    <= push_s ? (wptr_r + AW_ONE) : wptr_r;
      rptr_r    <= pop_s ? (rptr_r + AW_ONE) : rptr_r;
      count_r   <= count_s;
      wready_r  <= (count_s != FULL_CNT);
      state_r   <= state_s;
      sreg_r    <= sreg_s;
      bit_cnt_r <= bit_cnt_s;
      div_cnt_r <= div_cnt_s;
      gap_cnt_r <= gap_cnt_s;
      din_r     <= din_s;
      datav_r   <= datav_s;
      intcv_r   <= intcv_s;
      busy_r    <= (state_s != ST_IDLE);
    end
  end

  assign wr.wready = wready_r;
  assign din       = din_r;
  assign datav     = datav_r;
  assign intcv     = intcv_r;
  assign busy      = busy_r;
  assign level     = count_r;
endmodule

// File: tb/tb_lvdc_serial_loader.sv
// Directed bench for lvdc_serial_loader: default instance plus a no-parity instance.
`timescale 1ns/1ps
module tb_lvdc_serial_loader;
  logic       clk, rst;
  logic       hold, din, datav, intcv, busy;
  logic [2:0] level;
  logic       hold_np, din_np, datav_np, intcv_np, busy_np;
  logic [2:0] level_np;
  int         total, bad, icnt;

  lvdc_serial_loader_if #(.WORD_W(26)) wif ();
  lvdc_serial_loader_if #(.WORD_W(26)) wif_np ();

  lvdc_serial_loader dut (
    .clk(clk), .rst(rst), .wr(wif), .hold(hold), .din(din),
    .datav(datav), .intcv(intcv), .busy(busy), .level(level)
  );

  lvdc_serial_loader #(.PARITY_EN(0)) dut_np (
    .clk(clk), .rst(rst), .wr(wif_np), .hold(hold_np), .din(din_np),
    .datav(datav_np), .intcv(intcv_np), .busy(busy_np), .level(level_np)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (intcv === 1'b1) icnt <= icnt + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [25:0] d);
    wif.wdata  = d;
    wif.wvalid = 1'b1;
    step();
    wif.wvalid = 1'b0;
  endtask

  // Waits (bounded) for DATAV, then collects one word sampling mid-bit.
  task automatic get_word(input bit np, input int hold_at, output logic [31:0] w,
                          output int hi, output int wt, output logic ic);
    w = '0; hi = 0; wt = 0;
    while (((np ? datav_np : datav) !== 1'b1) && wt < 3000) begin
      step();
      wt++;
    end
    while (((np ? datav_np : datav) === 1'b1) && hi < 400) begin
      if ((hi % 4) == 2) w = {w[30:0], (np ? din_np : din)};
      if (hi == hold_at) hold = 1'b1;
      hi++;
      step();
    end
    ic = np ? intcv_np : intcv;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    total++;
    if ({din, datav, intcv, busy, level, wif.wready} !== 8'b0000_0001) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=00000001", {din, datav, intcv, busy, level, wif.wready});
    end
    total++;
    if ({din_np, datav_np, intcv_np, busy_np, level_np, wif_np.wready} !== 8'b0000_0001) begin
      bad++;
      $display("FAIL reset_outputs_np got=%b want=00000001",
               {din_np, datav_np, intcv_np, busy_np, level_np, wif_np.wready});
    end
  endtask

  task automatic test_single_word();
    logic [31:0] w; int hi, wt, i0; logic ic;
    i0 = icnt;
    push(26'h2AAAAAA);
    total++;
    if (level !== 3'd1 || datav !== 1'b0) begin
      bad++;
      $display("FAIL single_after_push level=%0d datav=%b want 1/0", level, datav);
    end
    get_word(1'b0, -1, w, hi, wt, ic);
    total++;
    if (wt !== 1) begin bad++; $display("FAIL single_latency got=%0d want=1", wt); end
    total++;
    if (hi !== 108) begin bad++; $display("FAIL single_datav_len got=%0d want=108", hi); end
    total++;
    if (w !== 32'h5555554) begin bad++; $display("FAIL single_bits got=%h want=5555554", w); end
    total++;
    if (ic !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_intcv_gap intcv=%b busy=%b want 1/1", ic, busy);
    end
    step();
    total++;
    if (intcv !== 1'b0) begin bad++; $display("FAIL single_intcv_width got=%b want=0", intcv); end
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b want=0", busy); end
    total++;
    if (icnt - i0 !== 1) begin bad++; $display("FAIL single_intcv_count got=%0d want=1", icnt - i0); end
  endtask

  task automatic test_parity();
    logic [31:0] w; int hi, wt; logic ic;
    push(26'h0000000);
    push(26'h0000001);
    get_word(1'b0, -1, w, hi, wt, ic);
    total++;
    if (w !== 32'h1) begin bad++; $display("FAIL parity_zero got=%h want=1", w); end
    get_word(1'b0, -1, w, hi, wt, ic);
    total++;
    if (w !== 32'h2) begin bad++; $display("FAIL parity_one got=%h want=2", w); end
    total++;
    if (wt !== 3) begin bad++; $display("FAIL back_to_back_gap got=%0d want=3", wt); end
    wif_np.wdata  = 26'h0000000;
    wif_np.wvalid = 1'b1;
    step();
    wif_np.wvalid = 1'b0;
    get_word(1'b1, -1, w, hi, wt, ic);
    total++;
    if (hi !== 104 || w !== 32'h0 || ic !== 1'b1) begin
      bad++;
      $display("FAIL noparity_zero len=%0d bits=%h intcv=%b want 104/0/1", hi, w, ic);
    end
    wif_np.wdata  = 26'h2000001;
    wif_np.wvalid = 1'b1;
    step();
    wif_np.wvalid = 1'b0;
    get_word(1'b1, -1, w, hi, wt, ic);
    total++;
    if (hi !== 104 || w !== 32'h2000001) begin
      bad++;
      $display("FAIL noparity_bits len=%0d bits=%h want 104/2000001", hi, w);
    end
    repeat (4) step();
  endtask

  task automatic test_fifo_full();
    logic [31:0] w; int hi, wt, i0, stray; logic ic;
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h2; exp_w[1] = 32'h4; exp_w[2] = 32'h7; exp_w[3] = 32'h8;
    hold = 1'b1;
    wif.wvalid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      wif.wdata = 26'(k);
      step();
      total++;
      if (level !== 3'((k > 4) ? 4 : k)) begin
        bad++;
        $display("FAIL full_level push=%0d got=%0d", k, level);
      end
      if (k >= 4) begin
        total++;
        if (wif.wready !== 1'b0) begin bad++; $display("FAIL full_wready push=%0d got=%b want=0", k, wif.wready); end
      end
    end
    wif.wvalid = 1'b0;
    i0 = icnt;
    hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      get_word(1'b0, -1, w, hi, wt, ic);
      total++;
      if (w !== exp_w[k] || wt !== ((k == 0) ? 1 : 3)) begin
        bad++;
        $display("FAIL full_word%0d bits=%h wait=%0d want=%h/%0d", k, w, wt, exp_w[k], (k == 0) ? 1 : 3);
      end
      if (k == 0) begin
        total++;
        if (level !== 3'd3 || wif.wready !== 1'b1) begin
          bad++;
          $display("FAIL full_drain level=%0d wready=%b want 3/1", level, wif.wready);
        end
      end
    end
    stray = 0;
    for (int c = 0; c < 200; c++) begin
      if (datav === 1'b1) stray++;
      step();
    end
    total++;
    if (stray !== 0 || level !== 3'd0 || icnt - i0 !== 4) begin
      bad++;
      $display("FAIL full_fifth_word stray=%0d level=%0d intcv=%0d want 0/0/4", stray, level, icnt - i0);
    end
  endtask

  task automatic test_hold_midword();
    logic [31:0] w; int hi, wt, stray; logic ic;
    push(26'h1234567);
    push(26'h0FEDCBA);
    get_word(1'b0, 41, w, hi, wt, ic);
    total++;
    if (w !== 32'h2468ACF || hi !== 108 || ic !== 1'b1) begin
      bad++;
      $display("FAIL hold_word1 bits=%h len=%0d intcv=%b want 2468acf/108/1", w, hi, ic);
    end
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      if (datav === 1'b1) stray++;
      step();
    end
    total++;
    if (stray !== 0 || level !== 3'd1) begin
      bad++;
      $display("FAIL hold_blocks stray=%0d level=%0d want 0/1", stray, level);
    end
    hold = 1'b0;
    get_word(1'b0, -1, w, hi, wt, ic);
    total++;
    if (wt !== 1 || w !== 32'h1FDB974) begin
      bad++;
      $display("FAIL hold_release wait=%0d bits=%h want 1/1fdb974", wt, w);
    end
    repeat (4) step();
  endtask

  task automatic test_reset_midword();
    int stray;
    hold = 1'b1;
    push(26'h0000011);
    push(26'h0000022);
    push(26'h0000033);
    hold = 1'b0;
    step();
    total++;
    if (datav !== 1'b1 || level !== 3'd2) begin
      bad++;
      $display("FAIL rstmid_setup datav=%b level=%0d want 1/2", datav, level);
    end
    repeat (20) step();
    rst = 1'b1;
    step();
    total++;
    if ({din, datav, intcv, busy, level, wif.wready} !== 8'b0000_0001) begin
      bad++;
      $display("FAIL rstmid_outputs got=%b want=00000001", {din, datav, intcv, busy, level, wif.wready});
    end
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 300; c++) begin
      if (datav === 1'b1) stray++;
      step();
    end
    total++;
    if (stray !== 0) begin bad++; $display("FAIL rstmid_stale got=%0d want=0", stray); end
  endtask

  task automatic test_push_pop();
    logic [31:0] w; int hi, wt; logic ic;
    hold = 1'b1;
    push(26'h3FFFFFF);
    hold = 1'b0;
    push(26'h0000002);
    total++;
    if (level !== 3'd1 || datav !== 1'b1) begin
      bad++;
      $display("FAIL pushpop_level level=%0d datav=%b want 1/1", level, datav);
    end
    get_word(1'b0, -1, w, hi, wt, ic);
    total++;
    if (w !== 32'h7FFFFFF || wt !== 0) begin
      bad++;
      $display("FAIL pushpop_first bits=%h wait=%0d want 7ffffff/0", w, wt);
    end
    get_word(1'b0, -1, w, hi, wt, ic);
    total++;
    if (w !== 32'h4 || wt !== 3) begin
      bad++;
      $display("FAIL pushpop_second bits=%h wait=%0d want 4/3", w, wt);
    end
    repeat (4) step();
  endtask

  initial begin
    total = 0; bad = 0; icnt = 0;
    rst = 1'b1; hold = 1'b0; hold_np = 1'b0;
    wif.wvalid = 1'b0; wif.wdata = '0;
    wif_np.wvalid = 1'b0; wif_np.wdata = '0;
    step();
    test_reset();
    test_single_word();
    test_parity();
    test_fifo_full();
    test_hold_midword();
    test_reset_midword();
    test_push_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lvdc_serial_loader.md
Name: lvdc_serial_loader

Overview:
- Upstream feeder for the LVDC core's serial data input.
- Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each word out MSB-first on DIN, with DATAV framing each bit and an optional odd-parity bit appended.
- Pulses INTCV once per completed word. Used by the simulation bench and the ground-command load path.

Parameters:
- WORD_W, 26: data bits per word.
- PARITY_EN, 1: 1 appends an odd-parity bit after the LSB; 0 omits it.
- FIFO_DEPTH, 4: word buffer depth, power of two, at least 2.
- BIT_DIV, 4: clock cycles each serial bit is held, at least 1.
- GAP_CYC, 2: idle cycles with DATAV low after each word, at least 1.

Ports:
- CLK, input, 1: single clock; every register updates on the rising edge.
- RST, input, 1: synchronous, active-high reset.
- WDATA, input, WORD_W: word to load.
- WVALID, input, 1: WDATA is valid.
- WREADY, output, 1: FIFO can accept a word.
- HOLD, input, 1: suppresses the start of new words.
- DIN, output, 1: serial data to the LVDC.
- DATAV, output, 1: DIN carries a valid bit.
- INTCV, output, 1: one-cycle end-of-word pulse.
- BUSY, output, 1: serializer not in IDLE.
- LEVEL, output, $clog2(FIFO_DEPTH+1): FIFO occupancy.

Behaviour:
- Reset (RST high at an edge): all outputs are registered and reset to 0 except WREADY, which is 1. FIFO is emptied, state goes to IDLE, all counters are 0. Reset mid-word drops DATAV the next cycle and discards the partial word and all buffered words.
- Push: occurs on an edge where WVALID and WREADY are both high. WREADY is the negation of full, taken from registered state only.
- A same-cycle pop does not raise WREADY in that cycle. It rises the cycle after LEVEL drops.
- Push and pop in the same cycle leave LEVEL unchanged.
- WVALID while full is ignored; WDATA is not captured.
- State machine:
  - IDLE: if FIFO non-empty and HOLD low, pop the head word into the shift register, compute the parity bit, clear the counters, and go to SHIFT. Otherwise stay.
  - SHIFT: DATAV=1; DIN = current bit, MSB of WDATA first, then the parity bit if enabled. Each bit is held exactly BIT_DIV cycles. After the last bit's final cycle, go to GAP.
  - GAP: DATAV=0, DIN=0. INTCV=1 on the first GAP cycle only. After GAP_CYC cycles, go to IDLE.
- Bits per word: NB = WORD_W + PARITY_EN.
- Parity: the parity bit is the XNOR-reduction of the data word, so data plus parity has an odd number of 1s.
- Latency: a word pushed into an empty FIFO at edge N is popped in cycle N+1 (IDLE), and its MSB appears on DIN with DATAV=1 in cycle N+2.
- Word period, back-to-back: NB·BIT_DIV + GAP_CYC + 1 cycles.
- HOLD:
  - Sampled only in IDLE. A word in progress always completes, including its GAP and INTCV.
  - HOLD rising during SHIFT has no effect until the next IDLE.
  - Pushes continue while HOLD is high.
- DIN and DATAV change only on edges where the bit boundary or state changes; there are no glitches between bit boundaries.
- BUSY=1 in SHIFT and GAP.
- LEVEL counts stored words only; it excludes the word currently in the shift register.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are derived from a count register, not from pointer equality.

Test Plan:
- Single word: defaults, push WDATA=26'h2AAAAAA into the empty FIFO at edge N.
  - DATAV=1 from cycle N+2 for 108 cycles (27 bits × 4).
  - DIN reads 1,0,1,0,… across 26 bits, then parity=0 (13 ones gives an odd total with parity 0).
  - INTCV pulses exactly once, in the first cycle after DATAV falls.
- Parity edges:
  - WDATA=0 gives a final parity bit of 1.
  - WDATA=26'h0000001 gives parity 0.
  - With PARITY_EN=0, WDATA=0 gives exactly 26 bits, 104 DATAV-high cycles.
- FIFO full: hold HOLD=1 and push 5 words 1..5 on consecutive cycles.
  - LEVEL reaches 4 and WREADY drops after the 4th push; word 5 is not accepted.
  - Release HOLD: words 1..4 are emitted in order, spaced 111 cycles apart, with 4 INTCV pulses.
- HOLD mid-word: load two words, then raise HOLD during bit 10 of word 1.
  - Word 1 completes with its INTCV pulse.
  - Word 2 does not start while HOLD=1, and starts 1 cycle after HOLD falls.
- Reset mid-operation: assert RST during bit 5 of a word with LEVEL=2.
  - Next cycle: DATAV=0, DIN=0, LEVEL=0, BUSY=0, WREADY=1, INTCV=0.
  - After RST releases, no stale words are emitted.
- Simultaneous push/pop: with LEVEL=1 in IDLE and HOLD=0, push on the same edge as the pop.
  - LEVEL stays 1 and the pushed word is emitted second, unchanged.
